n64adv2_vbus_demux: RTL and testbench
=====================================

// Module: n64adv2_vbus_demux
// PURPOSE
// - Front end of the video path: takes registered N64 VD bus (nVDSYNC + 7-bit VD) and
//   demultiplexes the 4-phase word stream (sync, R, G, B) into one 28-bit pixel word + strobe.
// - Measures lines per field, derives PAL/NTSC and interlaced/progressive flags for PPU state.
// - Sits between the input register stage and the PPU/scaler and controller sync inputs.
// PARAMETERS
// - COLOR_W          7    width of one VD colour word
// - LINE_CNT_W       10   width of the line counter (saturates at all-ones)
// - PAL_LINE_THRESH  290  lines/field at or above which the field counts as PAL
// PORTS
// - N64_CLK_i     in   1          N64 video clock, single clock domain
// - N64_RST_i     in   1          synchronous reset, active-high
// - nVDSYNC_i     in   1          low marks the sync word on VD_i
// - VD_i          in   COLOR_W    multiplexed video data bus
// - vdata_o       out  4+3*COLOR_W {VS,CLAMP,HS,CS, R, G, B}; sync bits active-low as on bus
// - vdata_valid_o out  1          one-cycle strobe, vdata_o holds a complete pixel
// - pal_o         out  1          1 = last field >= PAL_LINE_THRESH lines
// - interlaced_o  out  1          1 = the last two fields had different line counts
// - bus_err_o     out  1          sticky: pixel aborted by early nVDSYNC
// BEHAVIOUR
// - Reset (sync, active-high): vdata_o=all ones on sync bits, zero on colour; valid=0;
//   pal_o=0; interlaced_o=0; bus_err_o=0; phase=IDLE; line counters=0. Reset wins over all.
// - Phase FSM, states IDLE,SYNC,R,G (next-state on every clock edge):
//   - any state, nVDSYNC_i=0: latch VD_i[3:0] as sync bits -> SYNC.
//   - SYNC & nVDSYNC_i=1: latch R -> R;  R & nVDSYNC_i=1: latch G -> G.
//   - G & nVDSYNC_i=1: latch B, load vdata_o with {sync,R,G,B}, valid_o=1 next cycle -> IDLE.
//   - IDLE & nVDSYNC_i=1: VD_i ignored, stay IDLE (covers idle/blank clocks between pixels).
// - Latency: valid_o rises on the edge after the clock that sampled B; vdata_o holds until
//   next valid. valid_o never high two cycles in a row.
// - Early nVDSYNC (low while in SYNC, R or G): partial pixel discarded, no strobe,
//   bus_err_o set (sticky until reset), new pixel starts from the new sync word.
// - Line counting on accepted pixels only: HS falling (prev HS=1, new HS=0) -> line_cnt+1,
//   saturating at 2^LINE_CNT_W-1.
// - VS falling edge (prev VS=1, new VS=0) ends field: pal_o <= (line_cnt>=PAL_LINE_THRESH);
//   interlaced_o <= (line_cnt != prev_field_cnt); prev_field_cnt <= line_cnt; line_cnt <= 0.
//   If HS and VS fall in the same pixel, the line is counted before the field closes.
// - First field after reset compares against prev_field_cnt=0: interlaced_o is 1 after the
//   first field; valid from the second field on (consumer masks first field).
// - Flags change only at VS falling edge, never mid-field.
// CONFIGURATION
// - HPIX_CNT_EN defined: extra port hpix_o out 11 = pixels between the last two HS falling
//   edges (counts valid strobes, saturates at 2047, updated at HS fall, reset 0).
// - HPIX_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset held 3 clocks mid-pixel -> valid=0, pal/il/err=0, next sync word starts clean.
// - nVDSYNC low 1 of every 4 clocks, VD seq 0x0F,0x11,0x22,0x33 -> vdata_o=0xF_11_22_33
//   (sync,R,G,B), valid one cycle after B; 5-clock cadence with idle -> same data, no error.
// - nVDSYNC low again after R only -> no strobe, bus_err_o=1 stays set, next pixel correct.
// - Fields of 263/263 lines -> pal_o=0, interlaced_o=0 from 2nd VS; 312/313 -> pal_o=1,
//   interlaced_o=1.
// - 1100 HS pulses without VS -> counter saturates at 1023, next VS -> pal_o=1, no wrap.
// - HPIX_CNT_EN: 320 pixels per line -> hpix_o=320 after 2nd HS fall; macro off -> builds.

Source files
------------

// File: rtl/n64adv2_vbus_demux.sv
// rtl/n64adv2_vbus_demux.sv - N64 VD bus demux: 4-phase words to pixel, field line count, PAL/interlace flags.
// Optional HPIX_CNT_EN adds hpix_o (pixels between the last two HS falling edges).
module n64adv2_vbus_demux #(
  parameter int COLOR_W         = 7,
  parameter int LINE_CNT_W      = 10,
  parameter int PAL_LINE_THRESH = 290
) (
  input  logic                     N64_CLK_i,
  input  logic                     N64_RST_i,
  input  logic                     nVDSYNC_i,
  input  logic [COLOR_W-1:0]       VD_i,
  output logic [4+3*COLOR_W-1:0]   vdata_o,
  output logic                     vdata_valid_o,
  output logic                     pal_o,
  output logic                     interlaced_o,
  output logic                     bus_err_o
`ifdef HPIX_CNT_EN
  ,
  output logic [10:0]              hpix_o
`endif
);

  localparam int VDATA_W = 4 + 3*COLOR_W;
  localparam int HS_BIT  = 3*COLOR_W + 1;
  localparam int VS_BIT  = 3*COLOR_W + 3;
  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_CNT_W-1:0] LINE_ONE = {{(LINE_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LINE_CNT_W-1:0] PAL_THR  = PAL_LINE_THRESH[LINE_CNT_W-1:0];

  typedef enum logic [1:0] {PH_IDLE, PH_SYNC, PH_R, PH_G} phase_e;

  phase_e                 phase_q, phase_d;
  logic [3:0]             sync_q, sync_d;
  logic [COLOR_W-1:0]     r_q, r_d, g_q, g_d;
  logic [VDATA_W-1:0]     vdata_q, vdata_d;
  logic                   valid_q, valid_d;
  logic                   pal_q, pal_d;
  logic                   il_q, il_d;
  logic                   err_q, err_d;
  logic [LINE_CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [LINE_CNT_W-1:0]  prev_cnt_q, prev_cnt_d;
  logic                   accept;
  logic                   hs_fall, vs_fall;
  logic [LINE_CNT_W-1:0]  lines_now;
`ifdef HPIX_CNT_EN
  logic [10:0]            pix_cnt_q, pix_cnt_d;
  logic [10:0]            hpix_q, hpix_d;
`endif

  // Edges are judged against the last accepted pixel, so idle clocks never create edges.
  assign hs_fall = vdata_q[HS_BIT] & ~sync_q[1];
  assign vs_fall = vdata_q[VS_BIT] & ~sync_q[3];

  always_comb begin
    phase_d    = phase_q;
    sync_d     = sync_q;
    r_d        = r_q;
    g_d        = g_q;
    vdata_d    = vdata_q;
    pal_d      = pal_q;
    il_d       = il_q;
    err_d      = err_q;
    line_cnt_d = line_cnt_q;
    prev_cnt_d = prev_cnt_q;
    accept     = 1'b0;
    lines_now  = line_cnt_q;
`ifdef HPIX_CNT_EN
    pix_cnt_d  = pix_cnt_q;
    hpix_d     = hpix_q;
`endif

    if (!nVDSYNC_i) begin
      if (phase_q != PH_IDLE) err_d = 1'b1;
      sync_d  = VD_i[3:0];
      phase_d = PH_SYNC;
    end else begin
      case (phase_q)
        PH_SYNC: begin r_d = VD_i; phase_d = PH_R; end
        PH_R:    begin g_d = VD_i; phase_d = PH_G; end
        PH_G:    begin accept = 1'b1; phase_d = PH_IDLE; end
        default: ;
      endcase
    end

    if (accept) begin
      vdata_d = {sync_q, r_q, g_q, VD_i};
      // A line whose HS falls with VS still belongs to the closing field.
      if (hs_fall && line_cnt_q != LINE_MAX) lines_now = line_cnt_q + LINE_ONE;
      line_cnt_d = lines_now;
      if (vs_fall) begin
        pal_d      = (lines_now >= PAL_THR);
        il_d       = (lines_now != prev_cnt_q);
        prev_cnt_d = lines_now;
        line_cnt_d = '0;
      end
`ifdef HPIX_CNT_EN
      if (hs_fall) begin
        hpix_d    = pix_cnt_q;
        pix_cnt_d = 11'd1;
      end else if (pix_cnt_q != 11'h7FF) begin
        pix_cnt_d = pix_cnt_q + 11'd1;
      end
`endif
    end
    valid_d = accept;
  end

  always_ff @(posedge N64_CLK_i) begin
    if (N64_RST_i) begin
      phase_q    <= PH_IDLE;
      sync_q     <= 4'hF;
      r_q        <= '0;
      g_q        <= '0;
      vdata_q    <= {4'hF, {(3*COLOR_W){1'b0}}};
      valid_q    <= 1'b0;
      pal_q      <= 1'b0;
      il_q       <= 1'b0;
      err_q      <= 1'b0;
      line_cnt_q <= '0;
      prev_cnt_q <= '0;
`ifdef HPIX_CNT_EN
      pix_cnt_q  <= '0;
      hpix_q     <= '0;
`endif
    end else begin
      phase_q    <= phase_d;
      sync_q     <= sync_d;
      r_q        <= r_d;
      g_q        <= g_d;
      vdata_q    <= vdata_d;
      valid_q    <= valid_d;
      pal_q      <= pal_d;
      il_q       <= il_d;
      err_q      <= err_d;
      line_cnt_q <= line_cnt_d;
      prev_cnt_q <= prev_cnt_d;
`ifdef HPIX_CNT_EN
      pix_cnt_q  <= pix_cnt_d;
      hpix_q     <= hpix_d;
`endif
    end
  end

  assign vdata_o       = vdata_q;
  assign vdata_valid_o = valid_q;
  assign pal_o         = pal_q;
  assign interlaced_o  = il_q;
  assign bus_err_o     = err_q;
`ifdef HPIX_CNT_EN
  assign hpix_o        = hpix_q;
`endif

endmodule

// File: tb/tb_n64adv2_vbus_demux.sv
// tb/tb_n64adv2_vbus_demux.sv - self-checking bench for n64adv2_vbus_demux (queue-based bus model).
module tb_n64adv2_vbus_demux;

  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         nvd = 1'b1;
  logic [6:0]   vd  = '0;
  logic [W-1:0] vdata;
  logic         valid, pal, il, err;
`ifdef HPIX_CNT_EN
  logic [10:0]  hpix;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  n64adv2_vbus_demux dut (
    .N64_CLK_i     (clk),
    .N64_RST_i     (rst),
    .nVDSYNC_i     (nvd),
    .VD_i          (vd),
    .vdata_o       (vdata),
    .vdata_valid_o (valid),
    .pal_o         (pal),
    .interlaced_o  (il),
    .bus_err_o     (err)
`ifdef HPIX_CNT_EN
    ,
    .hpix_o        (hpix)
`endif
  );

  always #5 clk = ~clk;

  // Bus model: words collected since the last sync word, whole-number line bookkeeping.
  logic [6:0]   words[$];
  logic [W-1:0] m_vdata;
  logic         m_valid, m_pal, m_il, m_err;
  int           m_lines, m_prev, m_pix, m_hpix;
  bit           started = 0;

  task automatic model_pixel();
    logic [W-1:0] px;
    bit hs_f, vs_f;
    px   = {words[0][3:0], words[1], words[2], words[3]};
    hs_f = m_vdata[22] && !px[22];
    vs_f = m_vdata[24] && !px[24];
    if (hs_f) begin
      if (m_lines < 1023) m_lines++;
      m_hpix = m_pix;
      m_pix  = 1;
    end else if (m_pix < 2047) begin
      m_pix++;
    end
    if (vs_f) begin
      m_pal   = (m_lines >= 290);
      m_il    = (m_lines != m_prev);
      m_prev  = m_lines;
      m_lines = 0;
    end
    m_vdata = px;
    m_valid = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      words.delete();
      m_vdata = {4'hF, 21'h0};
      m_valid = 0; m_pal = 0; m_il = 0; m_err = 0;
      m_lines = 0; m_prev = 0; m_pix = 0; m_hpix = 0;
      started = 1;
    end else begin
      m_valid = 0;
      if (!nvd) begin
        if (words.size() != 0) m_err = 1;
        words.delete();
        words.push_back(vd);
      end else if (words.size() != 0) begin
        words.push_back(vd);
        if (words.size() == 4) begin
          model_pixel();
          words.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("vdata", 32'(vdata), 32'(m_vdata));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("pal",   32'(pal),   32'(m_pal));
      chk("il",    32'(il),    32'(m_il));
      chk("err",   32'(err),   32'(m_err));
`ifdef HPIX_CNT_EN
      chk("hpix",  32'(hpix),  32'(m_hpix));
`endif
    end
  end

  task automatic drive(input logic n, input logic [6:0] d);
    nvd = n;
    vd  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send_pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                            input logic [6:0] b, input int idle);
    drive(1'b0, {3'b000, s});
    drive(1'b1, r);
    drive(1'b1, g);
    drive(1'b1, b);
    for (int i = 0; i < idle; i++) drive(1'b1, 7'h55);
  endtask

  // One line: HS-low pixel then HS-high pixel, VS high throughout.
  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) begin
      send_pixel(4'b1101, 7'h01, 7'h02, 7'h03, 0);
      send_pixel(4'b1111, 7'h04, 7'h05, 7'h06, 0);
    end
  endtask

  task automatic send_vs();
    send_pixel(4'b0111, 7'h00, 7'h00, 7'h00, 0);
  endtask

  logic [W-1:0] exp_px;

  initial begin
    drive(1'b1, 7'h00);
    drive(1'b1, 7'h00);
    drive(1'b1, 7'h00);
    rst = 1'b0;
    exp_px = {4'hF, 21'h0};
    chk("lit_reset_vdata", 32'(vdata), 32'(exp_px));
    chk("lit_reset_err", 32'(err), 32'd0);

    for (int i = 0; i < 3; i++) send_pixel(4'hF, 7'h11, 7'h22, 7'h33, 0);
    exp_px = {4'hF, 7'h11, 7'h22, 7'h33};
    chk("lit_valid_after_b", 32'(valid), 32'd1);
    drive(1'b1, 7'h00);
    chk("lit_px_4clk", 32'(vdata), 32'(exp_px));
    for (int i = 0; i < 3; i++) send_pixel(4'hF, 7'h11, 7'h22, 7'h33, 1);
    chk("lit_px_5clk", 32'(vdata), 32'(exp_px));
    chk("lit_no_err", 32'(err), 32'd0);

    drive(1'b0, 7'h0F);
    drive(1'b1, 7'h11);
    send_pixel(4'hF, 7'h44, 7'h55, 7'h66, 2);
    exp_px = {4'hF, 7'h44, 7'h55, 7'h66};
    chk("lit_abort_err", 32'(err), 32'd1);
    chk("lit_abort_px", 32'(vdata), 32'(exp_px));
    send_pixel(4'hF, 7'h11, 7'h22, 7'h33, 0);
    chk("lit_err_sticky", 32'(err), 32'd1);

    drive(1'b0, 7'h0F);
    drive(1'b1, 7'h11);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 7'h22);
    rst = 1'b0;
    chk("lit_rst_err", 32'(err), 32'd0);
    chk("lit_rst_valid", 32'(valid), 32'd0);
    send_pixel(4'hF, 7'h12, 7'h34, 7'h56, 1);
    exp_px = {4'hF, 7'h12, 7'h34, 7'h56};
    chk("lit_rst_clean_px", 32'(vdata), 32'(exp_px));

    send_vs();
    send_lines(263); send_vs();
    chk("lit_263a_il", 32'(il), 32'd1);
    send_lines(263); send_vs();
    chk("lit_263b_pal", 32'(pal), 32'd0);
    chk("lit_263b_il", 32'(il), 32'd0);
    send_lines(312); send_vs();
    chk("lit_312_pal", 32'(pal), 32'd1);
    chk("lit_312_il", 32'(il), 32'd1);
    send_lines(313); send_vs();
    chk("lit_313_pal", 32'(pal), 32'd1);
    chk("lit_313_il", 32'(il), 32'd1);
    send_lines(1100); send_vs();
    chk("lit_sat_pal", 32'(pal), 32'd1);

    // HS and VS fall together: that line counts toward the closing field (11 lines).
    send_lines(10);
    send_pixel(4'b0101, 7'h07, 7'h08, 7'h09, 0);
    chk("lit_hsvs_pal", 32'(pal), 32'd0);
    chk("lit_hsvs_il", 32'(il), 32'd1);

`ifdef HPIX_CNT_EN
    send_pixel(4'b1111, 7'h01, 7'h01, 7'h01, 0);
    for (int l = 0; l < 2; l++) begin
      send_pixel(4'b1101, 7'h01, 7'h01, 7'h01, 0);
      for (int p = 1; p < 320; p++) send_pixel(4'b1111, 7'h02, 7'h02, 7'h02, 0);
    end
    send_pixel(4'b1101, 7'h01, 7'h01, 7'h01, 0);
    chk("lit_hpix_320", 32'(hpix), 32'd320);
`endif

    drive(1'b1, 7'h00);
    drive(1'b1, 7'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
